// File: rtl/smr_pkg.sv
// Shared definitions for the Simple RISC Machine controller: ISA field codes,
// writeback select codes, controller states and decoded instruction classes.
// No logic; imported by instr_decoder and instr_sequencer.
package smr_pkg;

    // Top-level opcode field IR[15:13]
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // op field IR[12:11] under OP_MOV
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    // op field IR[12:11] under OP_ALU (also drives ALUop directly)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Register-file writeback source
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        DECODE = 3'd1,
        WR_IMM = 3'd2,
        GET_A  = 3'd3,
        GET_B  = 3'd4,
        EXEC   = 3'd5,
        WR_REG = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_ADD     = 3'd3,
        CLS_CMP     = 3'd4,
        CLS_AND     = 3'd5,
        CLS_MVN     = 3'd6
    } iclass_t;

endpackage

// File: rtl/instr_decoder.sv
// Purpose: split the instruction register into fields and classify it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows ir continuously.
// Ports: ir (16b instruction) -> opcode, op, rn, rd, sh, rm, sximm8, sximm5, iclass.
module instr_decoder
    import smr_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output iclass_t     iclass
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    always_comb begin
        iclass = CLS_ILLEGAL;
        if (opcode == OP_MOV) begin
            if (op == MOV_IMM)      iclass = CLS_MOV_IMM;
            else if (op == MOV_REG) iclass = CLS_MOV_REG;
        end else if (opcode == OP_ALU) begin
            case (op)
                ALU_ADD: iclass = CLS_ADD;
                ALU_CMP: iclass = CLS_CMP;
                ALU_AND: iclass = CLS_AND;
                default: iclass = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle controller sequencing regfile and datapath registers.
// Latency: s to w: MOV-imm 2, CMP/MOV-reg/MVN 4, ADD/AND 5 cycles.
// Backpressure: w=1 only in WAIT; s and load are ignored outside WAIT.
// Ports: clk, reset (sync, high); in/load/s in; w, regfile controls (readnum,
// writenum, write), datapath enables (loada/b/c/s, asel, bsel, vsel), IR
// fields (shift, ALUop, sximm8, sximm5) and a one-cycle illegal pulse out.
module instr_sequencer
    import smr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        illegal
);

    state_t      state;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic [2:0]  rn, rd, rm;
    iclass_t     iclass;

    instr_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (ALUop),
        .rn     (rn),
        .rd     (rd),
        .sh     (shift),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .iclass (iclass)
    );

    // IR only changes in WAIT, so it is stable for the whole instruction.
    // illegal is registered: it pulses in the WAIT cycle following a DECODE
    // that rejected the encoding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT;
            ir      <= 16'h0000;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                WAIT: begin
                    if (load) ir <= in;
                    if (s) state <= DECODE;
                end
                DECODE: begin
                    case (iclass)
                        CLS_MOV_IMM:                  state <= WR_IMM;
                        CLS_MOV_REG, CLS_MVN:         state <= GET_B;
                        CLS_ADD, CLS_CMP, CLS_AND:    state <= GET_A;
                        default: begin
                            state   <= WAIT;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                WR_IMM: state <= WAIT;
                GET_A:  state <= GET_B;
                GET_B:  state <= EXEC;
                EXEC:   state <= (iclass == CLS_CMP) ? WAIT : WR_REG;
                WR_REG: state <= WAIT;
                default: state <= WAIT;
            endcase
        end
    end

    // Moore outputs: depend only on state and IR.
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        case (state)
            WAIT: w = 1'b1;
            WR_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
            end
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            EXEC: begin
                // Single-operand instructions take 0 on the A side.
                asel = (iclass == CLS_MOV_REG) || (iclass == CLS_MVN);
                if (iclass == CLS_CMP) loads = 1'b1;
                else                   loadc = 1'b1;
            end
            WR_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int total = 0;
    int bad   = 0;

    instr_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Packed control view: {w,write,loada,loadb,loadc,loads,asel,bsel,illegal,readnum,writenum,vsel}
    typedef struct {
        logic        rst;
        logic        ld;
        logic        st;
        logic [15:0] din;
        logic [16:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [16:0] ex(input logic ew, ewr, ela, elb, elc, els, eas, eil,
                                       input logic [2:0] ern, ewn, input logic [1:0] evs);
        return {ew, ewr, ela, elb, elc, els, eas, 1'b0, eil, ern, ewn, evs};
    endfunction

    function automatic void add(input logic r, l, st, input logic [15:0] d, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.ld = l; v.st = st; v.din = d; v.exp = e;
        vt.push_back(v);
    endfunction

    function automatic logic [16:0] observed();
        return {w, write, loada, loadb, loadc, loads, asel, bsel, illegal,
                readnum, writenum, vsel};
    endfunction

    task automatic step(input logic r, l, st, input logic [15:0] d);
        reset = r; load = l; s = st; in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < vt.size(); i++) begin
            logic [16:0] got;
            step(vt[i].rst, vt[i].ld, vt[i].st, vt[i].din);
            got = observed();
            total++;
            if (got !== vt[i].exp) begin
                bad++;
                $display("FAIL vec%0d: got %b expected %b", i, got, vt[i].exp);
            end
        end
        vt.delete();
    endtask

    logic [16:0] E_WAIT, E_DEC;

    initial begin
        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
        E_WAIT = ex(1,0,0,0,0,0,0,0, 3'd0,3'd0,2'b00);
        E_DEC  = ex(0,0,0,0,0,0,0,0, 3'd0,3'd0,2'b00);

        // Reset with s held, then release: opcode 000 is illegal.
        add(1,0,1,16'h0000, E_WAIT);
        add(1,0,1,16'h0000, E_WAIT);
        run_table();
        chk16("reset_sximm8", sximm8, 16'h0000);
        add(0,0,1,16'h0000, E_DEC);
        add(0,0,0,16'h0000, ex(1,0,0,0,0,0,0,1, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // MOV R2,#7
        add(0,1,1,16'hD207, E_DEC);
        add(0,0,0,16'h0000, ex(0,1,0,0,0,0,0,0, 3'd0,3'd2,2'b01));
        add(0,0,0,16'h0000, E_WAIT);
        // ADD R5,R0,R1
        add(0,1,1,16'hA0A1, E_DEC);
        add(0,0,0,16'h0000, ex(0,0,1,0,0,0,0,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,1,0,0,0,0, 3'd1,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,0,1,0,0,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,1,0,0,0,0,0,0, 3'd0,3'd5,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // CMP R1,R0
        add(0,1,1,16'hA900, E_DEC);
        add(0,0,0,16'h0000, ex(0,0,1,0,0,0,0,0, 3'd1,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,1,0,0,0,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,0,0,1,0,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // MOV R7,R2
        add(0,1,1,16'hC0E2, E_DEC);
        add(0,0,0,16'h0000, ex(0,0,0,1,0,0,0,0, 3'd2,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,0,1,0,1,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,1,0,0,0,0,0,0, 3'd0,3'd7,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // MVN R5,R3
        add(0,1,1,16'hB8A3, E_DEC);
        add(0,0,0,16'h0000, ex(0,0,0,1,0,0,0,0, 3'd3,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,0,1,0,1,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,1,0,0,0,0,0,0, 3'd0,3'd5,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // AND R2,R2,R6
        add(0,1,1,16'hB246, E_DEC);
        add(0,0,0,16'h0000, ex(0,0,1,0,0,0,0,0, 3'd2,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,1,0,0,0,0, 3'd6,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,0,0,0,1,0,0,0, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, ex(0,1,0,0,0,0,0,0, 3'd0,3'd2,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        // Undefined MOV variant 110/01
        add(0,1,1,16'hC800, E_DEC);
        add(0,0,0,16'h0000, ex(1,0,0,0,0,0,0,1, 3'd0,3'd0,2'b00));
        add(0,0,0,16'h0000, E_WAIT);
        run_table();

        // MOV R2,#-5: sign extension and field outputs while idle.
        step(0,1,0,16'hD2FB);
        chk16("sximm8_neg", sximm8, 16'hFFFB);
        chk16("sximm5_neg", sximm5, 16'hFFFB);
        step(0,0,1,16'h0000);
        step(0,0,0,16'h0000);
        chk16("movimm_neg_wr", {12'h0, write, writenum}, {12'h0, 1'b1, 3'd2});
        step(0,0,0,16'h0000);
        chk16("movimm_neg_w", {15'h0, w}, 16'h0001);

        step(0,1,0,16'hB8B5);
        chk16("shift_aluop", {12'h0, shift, ALUop}, {12'h0, 2'b10, 2'b11});
        chk16("sximm5_b5", sximm5, 16'hFFF5);
        chk16("sximm8_b5", sximm8, 16'hFFB5);

        // Reset during GET_B of an ADD abandons it with no write.
        step(0,1,1,16'hA0A1);
        step(0,0,0,16'h0000);
        step(0,0,0,16'h0000);
        chk16("abort_getb", {13'h0, loadb, readnum}, {13'h0, 1'b1, 3'd1});
        step(1,0,0,16'h0000);
        chk16("abort_w", {14'h0, w, write}, 16'h0002);
        step(0,0,0,16'h0000);
        chk16("abort_idle", {14'h0, w, write}, 16'h0002);
        chk16("abort_ir_clear", sximm8, 16'h0000);

        // load mid-instruction is ignored.
        step(0,1,1,16'hD207);
        step(0,1,0,16'hD5FB);
        chk16("midload_wr", {11'h0, write, writenum, vsel}, {11'h0, 1'b1, 3'd2, 2'b01});
        chk16("midload_imm", sximm8, 16'h0007);
        step(0,1,0,16'hD5FB);
        chk16("midload_w", {15'h0, w}, 16'h0001);

        // s held high: WAIT immediately re-enters DECODE.
        step(0,0,1,16'h0000);
        chk16("s_held_dec", {15'h0, w}, 16'h0000);
        step(0,0,1,16'h0000);
        step(0,0,1,16'h0000);
        chk16("s_held_wait", {15'h0, w}, 16'h0001);
        step(0,0,1,16'h0000);
        chk16("s_held_restart", {15'h0, w}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
